mux4_sel_arbiter: RTL

Round-robin arbiter directly upstream of the 4:1 mux (`mux4_1`). It takes four channel requests and grants exactly one at a time. It drives the mux select pair `s1:s0` with the index of the granted channel. Grants are held until the owner releases or a hold timeout fires.

---
 rtl/mux4_sel_arbiter_if.sv | 12 +
 rtl/mux4_sel_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/mux4_sel_arbiter_if.sv
// mux4_sel_arbiter_if: request/grant and mux-select bundle between requesters and the arbiter
interface mux4_sel_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       busy;
  logic       tmo;
  modport master (output req, done, input gnt, s0, s1, busy, tmo);
  modport slave (input req, done, output gnt, s0, s1, busy, tmo);
endinterface

// File: rtl/mux4_sel_arbiter.sv
// mux4_sel_arbiter: round-robin 4-channel arbiter with hold timeout driving a 4:1 mux select
module mux4_sel_arbiter #(
  parameter int CNT_W    = 8,
  parameter int HOLD_MAX = 16
) (
  input logic               clk,
  input logic               rst,
  mux4_sel_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] last, last_n, own, own_n, sel, sel_n, w;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] gnt, gnt_n;
  logic busy, busy_n, tmo, tmo_n, rel_own, rel_to;
  assign bus.gnt  = gnt;
  assign bus.s0   = sel[0];
  assign bus.s1   = sel[1];
  assign bus.busy = busy;
  assign bus.tmo  = tmo;
  // next owner: first requester after last, scanned descending so the nearest one wins
  always_comb begin
    w = last;
    for (int k = 4; k >= 1; k--) if (bus.req[last + 2'(k)]) w = last + 2'(k);
  end
  assign rel_own = bus.done | ~bus.req[own];
  assign rel_to  = (HOLD_MAX != 0) && (cnt == CNT_W'(HOLD_MAX - 1));
  // next-state and registered-output values; owner release wins over timeout
  always_comb begin
    state_n = state;
    last_n  = last;
    own_n   = own;
    sel_n   = sel;
    cnt_n   = cnt;
    gnt_n   = gnt;
    busy_n  = busy;
    tmo_n   = 1'b0;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_n = GRANT;
        own_n   = w;
        sel_n   = w;
        cnt_n   = '0;
        gnt_n   = 4'b0001 << w;
        busy_n  = 1'b1;
      end
    end else begin
      cnt_n = &cnt ? cnt : cnt + 1'b1;
      if (rel_own || rel_to) begin
        state_n = IDLE;
        last_n  = own;
        gnt_n   = '0;
        busy_n  = 1'b0;
        tmo_n   = ~rel_own;
      end
    end
  end
  // state and output registers, cleared asynchronously with channel 0 next in line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 2'd3;
      own   <= 2'd0;
      sel   <= 2'd0;
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_n;
      last  <= last_n;
      own   <= own_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
      tmo   <= tmo_n;
    end
  end
endmodule
